imem_fetch_requester: RTL and testbench
=======================================

Name: imem_fetch_requester

Overview:
Processor-side initiator for the tagged memory bus: accepts 8-byte-aligned line fetch requests from the I-cache/prefetcher and holds them in a small miss-status table. It issues BUS_LOAD/DOUBLE commands, captures the transaction tag returned in mem2proc_response, and matches returning mem2proc_tag/mem2proc_data to produce fill events. It sits between the I-cache/victim/prefetch logic and the memory model.

Parameters:
NUM_ENTRIES, 4, number of outstanding-miss table entries (2..8).
TAG_W, 4, width of bus tags; tag 0 means "none/refused".

Ports:
clk  in  1  processor clock; all state updates on posedge.
rst  in  1  reset, synchronous, active-high.
req_valid  in  1  fetch request present.
req_addr  in  `XLEN  byte address; bits [2:0] ignored (line = 8 bytes).
req_ready  out  1  request accepted this cycle when req_valid && req_ready.
fill_valid  out  1  one-cycle pulse: line returned.
fill_addr  out  `XLEN  line address of fill, bits [2:0] = 0.
fill_data  out  64  returned line data.
proc2mem_command  out  2  BUS_NONE or BUS_LOAD; BUS_STORE never driven.
proc2mem_addr  out  `XLEN  address of issuing entry, bits [2:0] = 0.
proc2mem_data  out  64  constant 0.
proc2mem_size  out  MEM_SIZE  constant DOUBLE.
mem2proc_response  in  TAG_W  tag granted to the command held this cycle; 0 = refused.
mem2proc_data  in  64  load data qualified by mem2proc_tag.
mem2proc_tag  in  TAG_W  nonzero = data for that tag is valid this cycle.

Behaviour:
- Entry state: INVALID, PENDING (not yet accepted by memory), WAIT (tag held). Each entry stores line address [XLEN-1:3] and tag.
- Reset: all entries INVALID; fill_valid=0, fill_addr=0, fill_data=0; proc2mem_command=BUS_NONE; req_ready=1 from the first cycle after reset.
- req_ready = (any INVALID entry) OR (req_addr line matches a valid entry) OR (req_addr line matches the line being filled this cycle). It is combinational from registered state and inputs. It uses no same-cycle bypass of a freeing entry for allocation.
- Accept: if the line matches a PENDING/WAIT entry, or the entry completing this cycle, the request is merged with no new entry. Otherwise the lowest-index INVALID entry is allocated in PENDING at the posedge.
- Issue: lowest-index PENDING entry drives proc2mem_command=BUS_LOAD and proc2mem_addr combinationally from registered state. If none is PENDING, the command is BUS_NONE and the address is 0.
- Memory updates its outputs at negedge, so mem2proc_response for the held command is sampled at the posedge that ends the issue cycle. Nonzero response: entry goes PENDING→WAIT and stores the tag. Zero response: entry stays PENDING and the same command is re-presented next cycle (unbounded retry).
- Return: at a posedge with mem2proc_tag != 0 matching a WAIT entry's tag, the entry goes to INVALID. Next cycle fill_valid=1 with fill_addr and fill_data registered from that entry and mem2proc_data. An unmatched nonzero tag is ignored.
- Minimum request-to-fill latency is 1 (accept) + 1 (issue) + memory latency + 1 (register).
- Simultaneous events in one cycle are all legal: accept, issue-response and return, even on different entries. Return and response on the same entry cannot coincide.
- At most one fill per cycle, matching the bus.
- Assertions: no two WAIT entries hold the same tag; a tag is never captured as 0 into WAIT.
- Reset mid-operation clears the table. Tags returning after reset match nothing and are dropped.

Decomposition:
- Shared package (existing memory-bus package): BUS_NONE/BUS_LOAD/BUS_STORE, MEM_SIZE enum, NUM_MEM_TAGS, plus a new MSHR_STATE enum {INVALID, PENDING, WAIT} and an MSHR_ENTRY struct {state, line_addr, tag}.
- Sub-module: fetch_prio_enc, a parameterised lowest-index one-hot/index picker. It is instantiated twice: free-entry allocation and pending-entry issue.

Test Plan:
- Single miss: memory latency 4. req 0x100 at cycle 0 → BUS_LOAD 0x100 at cycle 1, response=1. mem2proc_tag=1 with data 0xDEADBEEF_CAFEF00D 4 cycles later → fill_valid with that data and fill_addr 0x100 the next cycle, 1 pulse.
- Refusal retry: response=0 for 3 cycles, then 2 → BUS_LOAD 0x200 held 4 cycles. The entry waits on tag 2, and tag 2 data fills 0x200.
- Merge: req 0x300 and then 0x304 two cycles later → only one BUS_LOAD is issued, only one fill is produced, and req_ready stays 1.
- Full table: with 4 outstanding lines, a 5th distinct req 0x500 sees req_ready=0. Once the fill for tag 3 returns, it is accepted the next cycle and placed in the freed entry.
- Out-of-order return: lines A (tag 1) and B (tag 2) outstanding, tag 2 returns first → fill B, then fill A. A stray tag 5 is ignored.
- Reset mid-flight: rst asserted while 2 entries wait → fill_valid=0, command BUS_NONE, req_ready=1. Tags arriving after reset produce no fill.

Source files
------------

// File: rtl/imem_fetch_requester_pkg.sv
// Memory-bus definitions shared by the processor-side bus initiators, plus the
// miss-status table entry types used by the instruction fetch requester.
`ifndef XLEN
`define XLEN 32
`endif

package imem_fetch_requester_pkg;

    localparam int XLEN         = `XLEN;
    localparam int LINE_W       = XLEN - 3;
    localparam int NUM_MEM_TAGS = 15;
    localparam int MAX_TAG_W    = 8;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        INVALID = 2'h0,
        PENDING = 2'h1,
        WAIT    = 2'h2
    } MSHR_STATE;

    // Tags are held at the widest supported bus tag; narrower buses zero-extend.
    typedef struct packed {
        MSHR_STATE             state;
        logic [LINE_W-1:0]     line_addr;
        logic [MAX_TAG_W-1:0]  tag;
    } MSHR_ENTRY;

    localparam MSHR_ENTRY EMPTY_ENTRY = '{state: INVALID, line_addr: '0, tag: '0};

endpackage

// File: rtl/imem_fetch_requester_prio_enc.sv
// Lowest-index picker: returns a one-hot grant and its binary index for the
// lowest set bit of req; any is set when at least one bit is requested.
module fetch_prio_enc #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; a path that leaves it unassigned infers a latch.
        grant = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/imem_fetch_requester.sv
// Instruction-fetch miss handler on the tagged memory bus: merges and tracks
// outstanding line fetches, issues BUS_LOAD commands and turns tag returns into fills.
module imem_fetch_requester
    import imem_fetch_requester_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    input  logic [`XLEN-1:0]  req_addr,
    output logic              req_ready,

    output logic              fill_valid,
    output logic [`XLEN-1:0]  fill_addr,
    output logic [63:0]       fill_data,

    output BUS_COMMAND        proc2mem_command,
    output logic [`XLEN-1:0]  proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    output MEM_SIZE           proc2mem_size,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    MSHR_ENTRY         entries_q [NUM_ENTRIES];
    MSHR_ENTRY         entries_d [NUM_ENTRIES];
    logic              fill_valid_q, fill_valid_d;
    logic [XLEN-1:0]   fill_addr_q,  fill_addr_d;
    logic [63:0]       fill_data_q,  fill_data_d;

    logic [LINE_W-1:0]      req_line;
    logic [NUM_ENTRIES-1:0] free_vec, pend_vec, hit_vec, ret_vec;
    logic [NUM_ENTRIES-1:0] alloc_grant, issue_grant;
    logic [IDX_W-1:0]       alloc_idx, issue_idx;
    logic                   alloc_any, issue_any;
    logic                   req_hit, alloc_en, resp_ok;

    assign req_line = req_addr[XLEN-1:3];

    // Per-entry classification, all from registered state and this cycle's inputs.
    always_comb begin
        free_vec = '0;
        pend_vec = '0;
        hit_vec  = '0;
        ret_vec  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_vec[i] = (entries_q[i].state == INVALID);
            pend_vec[i] = (entries_q[i].state == PENDING);
            hit_vec[i]  = (entries_q[i].state != INVALID) &&
                          (entries_q[i].line_addr == req_line);
            ret_vec[i]  = (entries_q[i].state == WAIT) && (mem2proc_tag != '0) &&
                          (entries_q[i].tag == MAX_TAG_W'(mem2proc_tag));
        end
    end

    fetch_prio_enc #(.N(NUM_ENTRIES)) u_alloc_pick (
        .req   (free_vec),
        .grant (alloc_grant),
        .idx   (alloc_idx),
        .any   (alloc_any)
    );

    fetch_prio_enc #(.N(NUM_ENTRIES)) u_issue_pick (
        .req   (pend_vec),
        .grant (issue_grant),
        .idx   (issue_idx),
        .any   (issue_any)
    );

    // An entry completing this cycle is still in WAIT, so hit_vec already
    // covers merging into the line being filled.
    assign req_hit   = |hit_vec;
    assign req_ready = alloc_any || req_hit;
    assign alloc_en  = req_valid && req_ready && !req_hit;
    assign resp_ok   = issue_any && (mem2proc_response != '0);

    always_comb begin
        entries_d    = entries_q;
        fill_valid_d = 1'b0;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc_en && alloc_grant[i]) begin
                entries_d[i] = '{state: PENDING, line_addr: req_line, tag: '0};
            end
            if (resp_ok && issue_grant[i]) begin
                entries_d[i].state = WAIT;
                entries_d[i].tag   = MAX_TAG_W'(mem2proc_response);
            end
            if (ret_vec[i]) begin
                entries_d[i].state = INVALID;
                fill_valid_d       = 1'b1;
                fill_addr_d        = {entries_q[i].line_addr, 3'b000};
                fill_data_d        = mem2proc_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples
        // pre-edge values; = here would make results depend on block ordering.
        if (rst) begin
            // NOTE: the whole table is cleared, not just the state field; it is a
            // few flops and keeps stale tags/addresses out of debug views.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= EMPTY_ENTRY;
            end
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
        end else begin
            entries_q    <= entries_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
        end
    end

    assign fill_valid       = fill_valid_q;
    assign fill_addr        = fill_addr_q;
    assign fill_data        = fill_data_q;
    assign proc2mem_command = issue_any ? BUS_LOAD : BUS_NONE;
    assign proc2mem_addr    = issue_any ? {entries_q[issue_idx].line_addr, 3'b000} : '0;
    assign proc2mem_data    = '0;
    assign proc2mem_size    = DOUBLE;

    logic unused_ok;
    assign unused_ok = ^{req_addr[2:0], alloc_idx};

    // Invariants on tags held by waiting entries.
    logic wait_tag_zero, wait_tag_dup;
    always_comb begin
        wait_tag_zero = 1'b0;
        wait_tag_dup  = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entries_q[i].state == WAIT && entries_q[i].tag == '0) begin
                wait_tag_zero = 1'b1;
            end
            for (int j = i + 1; j < NUM_ENTRIES; j++) begin
                if (entries_q[i].state == WAIT && entries_q[j].state == WAIT &&
                    entries_q[i].tag == entries_q[j].tag) begin
                    wait_tag_dup = 1'b1;
                end
            end
        end
    end

    a_wait_tag_nonzero: assert property (@(posedge clk) disable iff (rst) !wait_tag_zero);
    a_wait_tag_unique:  assert property (@(posedge clk) disable iff (rst) !wait_tag_dup);

endmodule

// File: tb/tb_imem_fetch_requester.sv
// Directed bench for imem_fetch_requester: a per-cycle vector table for the
// basic miss/retry/merge flows, then hand-written multi-cycle corner cases.
module tb_imem_fetch_requester;
    import imem_fetch_requester_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [XLEN-1:0]   req_addr;
    logic              req_ready;
    logic              fill_valid;
    logic [XLEN-1:0]   fill_addr;
    logic [63:0]       fill_data;
    BUS_COMMAND        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [63:0]       proc2mem_data;
    MEM_SIZE           proc2mem_size;
    logic [3:0]        mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [3:0]        mem2proc_tag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imem_fetch_requester #(.NUM_ENTRIES(4), .TAG_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .fill_valid        (fill_valid),
        .fill_addr         (fill_addr),
        .fill_data         (fill_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic [3:0]  resp;
        logic [3:0]  rtag;
        logic [63:0] rdata;
        logic        e_ready;
        BUS_COMMAND  e_cmd;
        logic [31:0] e_paddr;
        logic        e_fv;
        logic [31:0] e_faddr;
        logic [63:0] e_fdata;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] D_A = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D_B = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D_C = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D_D = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] D_E = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D_0 = 64'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t row(input logic rv, input logic [31:0] ra, input logic [3:0] resp,
                                 input logic [3:0] rtag, input logic [63:0] rdata,
                                 input logic e_ready, input BUS_COMMAND e_cmd,
                                 input logic [31:0] e_paddr, input logic e_fv,
                                 input logic [31:0] e_faddr, input logic [63:0] e_fdata);
        vec_t v;
        v.rv = rv; v.ra = ra; v.resp = resp; v.rtag = rtag; v.rdata = rdata;
        v.e_ready = e_ready; v.e_cmd = e_cmd; v.e_paddr = e_paddr;
        v.e_fv = e_fv; v.e_faddr = e_faddr; v.e_fdata = e_fdata;
        return v;
    endfunction

    // Inputs change at negedge like the memory model; outputs are read 1 time unit later.
    task automatic drive(input logic rv, input logic [31:0] ra, input logic [3:0] resp,
                         input logic [3:0] rtag, input logic [63:0] rdata);
        @(negedge clk);
        req_valid = rv; req_addr = ra; mem2proc_response = resp;
        mem2proc_tag = rtag; mem2proc_data = rdata;
        #1;
    endtask

    task automatic expect_bus(input string name, input logic e_ready, input BUS_COMMAND e_cmd,
                              input logic [31:0] e_paddr);
        check({name, " req_ready"}, 64'(req_ready), 64'(e_ready));
        check({name, " command"}, 64'(proc2mem_command), 64'(e_cmd));
        check({name, " paddr"}, 64'(proc2mem_addr), 64'(e_paddr));
    endtask

    task automatic expect_fill(input string name, input logic e_fv, input logic [31:0] e_faddr,
                               input logic [63:0] e_fdata);
        check({name, " fill_valid"}, 64'(fill_valid), 64'(e_fv));
        if (e_fv) begin
            check({name, " fill_addr"}, 64'(fill_addr), 64'(e_faddr));
            check({name, " fill_data"}, fill_data, e_fdata);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        drive(v.rv, v.ra, v.resp, v.rtag, v.rdata);
        expect_bus($sformatf("vec%0d", n), v.e_ready, v.e_cmd, v.e_paddr);
        expect_fill($sformatf("vec%0d", n), v.e_fv, v.e_faddr, v.e_fdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single miss, memory latency 4.
        vecs.push_back(row(1'b1, 32'h100, 4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd1, 4'd0, D_0, 1'b1, BUS_LOAD, 32'h100, 1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd1, D_A, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b1, 32'h100, D_A));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        // Refusal retry: three zero responses, then tag 2; low address bits ignored.
        vecs.push_back(row(1'b1, 32'h205, 4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_LOAD, 32'h200, 1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_LOAD, 32'h200, 1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_LOAD, 32'h200, 1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd2, 4'd0, D_0, 1'b1, BUS_LOAD, 32'h200, 1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd2, D_B, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b1, 32'h200, D_B));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        // Merge: 0x304 joins the outstanding 0x300 fetch.
        vecs.push_back(row(1'b1, 32'h300, 4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd3, 4'd0, D_0, 1'b1, BUS_LOAD, 32'h300, 1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b1, 32'h304, 4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd3, D_C, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b1, 32'h300, D_C));
        vecs.push_back(row(1'b0, 32'h0,   4'd0, 4'd0, D_0, 1'b1, BUS_NONE, 32'h0,   1'b0, 32'h0, D_0));

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_bus("reset", 1'b1, BUS_NONE, 32'h0);
        check("reset fill_valid", 64'(fill_valid), 64'd0);
        check("reset fill_addr", 64'(fill_addr), 64'd0);
        check("reset fill_data", fill_data, 64'd0);
        check("reset size", 64'(proc2mem_size), 64'(DOUBLE));
        check("reset pdata", proc2mem_data, 64'd0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Full table: four lines outstanding on tags 1..4, then 0x500 waits for a free entry.
        drive(1'b1, 32'h400, 4'd0, 4'd0, D_0); expect_bus("full0", 1'b1, BUS_NONE, 32'h0);
        drive(1'b1, 32'h410, 4'd1, 4'd0, D_0); expect_bus("full1", 1'b1, BUS_LOAD, 32'h400);
        drive(1'b1, 32'h420, 4'd2, 4'd0, D_0); expect_bus("full2", 1'b1, BUS_LOAD, 32'h410);
        drive(1'b1, 32'h430, 4'd3, 4'd0, D_0); expect_bus("full3", 1'b1, BUS_LOAD, 32'h420);
        drive(1'b1, 32'h500, 4'd4, 4'd0, D_0); expect_bus("full4", 1'b0, BUS_LOAD, 32'h430);
        drive(1'b1, 32'h500, 4'd0, 4'd0, D_0); expect_bus("full5", 1'b0, BUS_NONE, 32'h0);
        drive(1'b1, 32'h500, 4'd0, 4'd3, D_C); expect_bus("full6 no bypass", 1'b0, BUS_NONE, 32'h0);
        expect_fill("full6", 1'b0, 32'h0, D_0);
        drive(1'b1, 32'h500, 4'd0, 4'd0, D_0); expect_bus("full7", 1'b1, BUS_NONE, 32'h0);
        expect_fill("full7", 1'b1, 32'h420, D_C);
        drive(1'b1, 32'h600, 4'd3, 4'd0, D_0); expect_bus("full8 refill", 1'b0, BUS_LOAD, 32'h500);
        drive(1'b1, 32'h410, 4'd0, 4'd0, D_0); expect_bus("full9 merge", 1'b1, BUS_NONE, 32'h0);
        drive(1'b1, 32'h400, 4'd0, 4'd1, D_A); expect_bus("full10 merge done", 1'b1, BUS_NONE, 32'h0);
        drive(1'b0, 32'h0, 4'd0, 4'd2, D_B);   expect_fill("drain0", 1'b1, 32'h400, D_A);
        drive(1'b0, 32'h0, 4'd0, 4'd4, D_D);   expect_fill("drain1", 1'b1, 32'h410, D_B);
        drive(1'b0, 32'h0, 4'd0, 4'd3, D_E);   expect_fill("drain2", 1'b1, 32'h430, D_D);
        drive(1'b0, 32'h0, 4'd0, 4'd0, D_0);   expect_fill("drain3", 1'b1, 32'h500, D_E);
        drive(1'b0, 32'h0, 4'd0, 4'd0, D_0);   expect_fill("drain4", 1'b0, 32'h0, D_0);
        expect_bus("drained", 1'b1, BUS_NONE, 32'h0);

        // Out-of-order return with a stray tag.
        drive(1'b1, 32'h700, 4'd0, 4'd0, D_0); expect_bus("ooo0", 1'b1, BUS_NONE, 32'h0);
        drive(1'b1, 32'h708, 4'd1, 4'd0, D_0); expect_bus("ooo1", 1'b1, BUS_LOAD, 32'h700);
        drive(1'b0, 32'h0, 4'd2, 4'd0, D_0);   expect_bus("ooo2", 1'b1, BUS_LOAD, 32'h708);
        drive(1'b0, 32'h0, 4'd0, 4'd5, D_E);   expect_fill("ooo3", 1'b0, 32'h0, D_0);
        drive(1'b0, 32'h0, 4'd0, 4'd2, D_B);   expect_fill("ooo4 stray", 1'b0, 32'h0, D_0);
        drive(1'b0, 32'h0, 4'd0, 4'd1, D_A);   expect_fill("ooo5 fill B", 1'b1, 32'h708, D_B);
        drive(1'b0, 32'h0, 4'd0, 4'd0, D_0);   expect_fill("ooo6 fill A", 1'b1, 32'h700, D_A);
        drive(1'b0, 32'h0, 4'd0, 4'd0, D_0);   expect_fill("ooo7", 1'b0, 32'h0, D_0);

        // Reset while two entries wait; late tags must be dropped.
        drive(1'b1, 32'h800, 4'd0, 4'd0, D_0);
        drive(1'b1, 32'h810, 4'd1, 4'd0, D_0); expect_bus("rst1", 1'b1, BUS_LOAD, 32'h800);
        drive(1'b0, 32'h0, 4'd2, 4'd0, D_0);   expect_bus("rst2", 1'b1, BUS_LOAD, 32'h810);
        drive(1'b0, 32'h0, 4'd0, 4'd0, D_0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 4'd0, 4'd1, D_A);
        rst = 1'b0;
        expect_bus("post-rst", 1'b1, BUS_NONE, 32'h0);
        check("post-rst fill_valid", 64'(fill_valid), 64'd0);
        check("post-rst fill_addr", 64'(fill_addr), 64'd0);
        drive(1'b0, 32'h0, 4'd0, 4'd2, D_B);   expect_fill("post-rst tag1", 1'b0, 32'h0, D_0);
        drive(1'b0, 32'h0, 4'd0, 4'd0, D_0);   expect_fill("post-rst tag2", 1'b0, 32'h0, D_0);
        expect_bus("post-rst idle", 1'b1, BUS_NONE, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
